// File: rtl/mdu_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide unit.
// The master issues operations and reads HI/LO back; the unit itself is the slave.
interface mdu_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] data1_E;
    logic [31:0] data2_E;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, mdop, data1_E, data2_E,
        input  busy, hi_out, lo_out
    );

    modport slave (
        input  start, mdop, data1_E, data2_E,
        output busy, hi_out, lo_out
    );
endinterface

// File: rtl/mdu.sv
// MIPS-style multiply/divide unit with HI/LO registers and a fixed busy latency.
// Results are computed on the accepting edge and held pending until the count expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MUL = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q;
    logic [63:0]   pend_q;

    // Opcode decode
    logic op_mul, op_div, op_mthi, op_mtlo, signed_op;
    assign op_mul    = (bus.mdop[2:1] == 2'b00);
    assign op_div    = (bus.mdop[2:1] == 2'b01);
    assign op_mthi   = (bus.mdop == 3'b100);
    assign op_mtlo   = (bus.mdop == 3'b101);
    assign signed_op = ~bus.mdop[0];

    // Multiply: sign- or zero-extend to 64 bits so one multiplier covers mult and multu.
    logic [63:0] a_ext, b_ext, product;
    assign a_ext   = {{32{signed_op & bus.data1_E[31]}}, bus.data1_E};
    assign b_ext   = {{32{signed_op & bus.data2_E[31]}}, bus.data2_E};
    assign product = a_ext * b_ext;

    // Divide on magnitudes, then restore signs; this keeps 0x80000000 / -1 well defined.
    logic        a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [63:0] div_result;
    assign a_neg      = signed_op & bus.data1_E[31];
    assign b_neg      = signed_op & bus.data2_E[31];
    assign a_mag      = a_neg ? (~bus.data1_E + 32'd1) : bus.data1_E;
    assign b_mag      = b_neg ? (~bus.data2_E + 32'd1) : bus.data2_E;
    assign div_zero   = (bus.data2_E == 32'd0);
    assign b_safe     = div_zero ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
    // A zero divisor re-captures the current HI/LO so the write-back leaves them unchanged.
    assign div_result = div_zero ? {hi_q, lo_q} : {rem, quot};

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && op_mul)      state_d = MUL;
                else if (bus.start && op_div) state_d = DIV;
            end
            MUL, DIV: begin
                if (cnt_q == CNT_ONE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    logic idle, accept_mul, accept_div, do_mthi, do_mtlo, write_back;
    always_comb begin
        idle       = (state_q == IDLE);
        accept_mul = idle & bus.start & op_mul;
        accept_div = idle & bus.start & op_div;
        do_mthi    = idle & bus.start & op_mthi;
        do_mtlo    = idle & bus.start & op_mtlo;
        write_back = ~idle & (cnt_q == CNT_ONE);
    end

    // State, counter, pending result and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;

            if (accept_mul) begin
                pend_q <= product;
                cnt_q  <= CNT_MUL;
            end else if (accept_div) begin
                pend_q <= div_result;
                cnt_q  <= CNT_DIV;
            end else if (!idle) begin
                cnt_q  <= cnt_q - CNT_ONE;
            end

            if (write_back) begin
                hi_q <= pend_q[63:32];
                lo_q <= pend_q[31:0];
            end else if (do_mthi) begin
                hi_q <= bus.data1_E;
            end else if (do_mtlo) begin
                lo_q <= bus.data1_E;
            end
        end
    end

    assign bus.busy   = ~idle;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule
